// File: rtl/barrel_pkg.sv
// barrel_pkg
//   Shared definitions for the barrel_shifter / barrel_unshifter pair.
//   - BARREL_WIDTH / BARREL_AMT_W : default data and rotate-amount widths
//   - state_t                     : control FSM encoding of barrel_unshifter
package barrel_pkg;

   localparam int unsigned BARREL_WIDTH = 8;
   localparam int unsigned BARREL_AMT_W = 3;

   // The unused code 2'b11 is steered back to IDLE by the FSM default branch.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/barrel_unshifter_rot1_step.sv
// rot1_step
//   Combinational single-position rotator.
//   Ports:
//     dir    : 0 = rotate right by one, 1 = rotate left by one
//     data   : input word
//     result : rotated word
module rot1_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             dir,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      if (dir) begin
         result = {data[WIDTH-2:0], data[WIDTH-1]};
      end else begin
         result = {data[0], data[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/barrel_unshifter.sv
// barrel_unshifter
//   Sequential inverse of the left-rotating barrel_shifter. A job (word,
//   amount, direction) is accepted on a valid/ready handshake, rotated one
//   bit position per clock, and the result is offered on an output
//   valid/ready handshake. All outputs are register decodes.
//   Ports:
//     clk, rst             : clock, asynchronous active-high reset
//     in_valid / in_ready  : input handshake (in_ready high only in IDLE)
//     in_data              : rotated word
//     in_amt               : positions to rotate
//     in_dir               : 0 = rotate right, 1 = rotate left
//     out_valid / out_ready: output handshake (out_valid high only in DONE)
//     out_data             : restored word, held stable while in DONE
module barrel_unshifter
   import barrel_pkg::*;
#(
   parameter int unsigned WIDTH = BARREL_WIDTH,
   parameter int unsigned AMT_W = BARREL_AMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   data_r, data_nxt;
   logic [AMT_W-1:0]   cnt_r, cnt_nxt;
   logic               dir_r, dir_nxt;
   logic [WIDTH-1:0]   rot_out;

   rot1_step #(
      .WIDTH (WIDTH)
   ) u_rot1_step (
      .dir    (dir_r),
      .data   (data_r),
      .result (rot_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         data_r <= '0;
         cnt_r  <= '0;
         dir_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         data_r <= data_nxt;
         cnt_r  <= cnt_nxt;
         dir_r  <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = data_r;
      cnt_nxt   = cnt_r;
      dir_nxt   = dir_r;
      case (state)
         IDLE: begin
            if (in_valid) begin
               data_nxt  = in_data;
               cnt_nxt   = in_amt;
               dir_nxt   = in_dir;
               state_nxt = (in_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_nxt = rot_out;
            cnt_nxt  = cnt_r - AMT_W'(1);
            // Last step happens on the edge where the counter still reads 1.
            if (cnt_r == AMT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = data_r;

endmodule
